// File: rtl/usb_rx_unstuff_assembler_if.sv
// Receive-path bundle between the NRZI decoder side and the packet/PID layer.
// pkt_len (and LEN_W) exist only when RX_PKT_LEN_EN is defined.
interface usb_rx_unstuff_assembler_if;
`ifdef RX_PKT_LEN_EN
    parameter int LEN_W = 7;
`endif

    logic       bit_strobe;
    logic       d_bit;
    logic       eop;
    logic [7:0] rx_data;
    logic       byte_valid;
    logic       rcving;
    logic       pkt_done;
    logic       stuff_err;
    logic       byte_err;
`ifdef RX_PKT_LEN_EN
    logic [LEN_W-1:0] pkt_len;
`endif

    modport master (
        output bit_strobe, d_bit, eop,
`ifdef RX_PKT_LEN_EN
        input  pkt_len,
`endif
        input  rx_data, byte_valid, rcving, pkt_done, stuff_err, byte_err
    );

    modport slave (
        input  bit_strobe, d_bit, eop,
`ifdef RX_PKT_LEN_EN
        output pkt_len,
`endif
        output rx_data, byte_valid, rcving, pkt_done, stuff_err, byte_err
    );
endinterface

// File: rtl/usb_rx_unstuff_assembler.sv
// USB RX SYNC hunt, bit unstuffing and LSB-first byte assembly.
// Optional byte counter on pkt_len enabled by the RX_PKT_LEN_EN macro.
//
// state    | meaning
// IDLE     | hunting for SYNC (00000001) in the decoded bit stream
// DATA     | inside a packet: unstuffing and assembling bytes
// ERR_WAIT | stuffing violation seen, discarding bits until EOP
// EOP_WAIT | EOP handled, waiting for the bus to leave SE0
module usb_rx_unstuff_assembler #(
    parameter int STUFF_LIMIT = 6
`ifdef RX_PKT_LEN_EN
    , parameter int LEN_W = 7
`endif
) (
    input  logic                          clk,
    input  logic                          n_rst,
    usb_rx_unstuff_assembler_if.slave     bus
);
    localparam int                ONES_W    = $clog2(STUFF_LIMIT + 1);
    localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LIMIT);
    localparam logic [7:0]        SYNC_PAT  = 8'h80;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA     = 2'd1,
        ERR_WAIT = 2'd2,
        EOP_WAIT = 2'd3
    } state_t;

    state_t            state_q;
    logic [7:0]        sr_q;
    logic [7:0]        sr_d;
    logic [2:0]        bit_cnt_q;
    logic [ONES_W-1:0] ones_cnt_q;
    logic [7:0]        rx_data_q;
    logic              byte_valid_q;
    logic              rcving_q;
    logic              pkt_done_q;
    logic              stuff_err_q;
    logic              byte_err_q;
`ifdef RX_PKT_LEN_EN
    logic [LEN_W-1:0]  pkt_len_q;
`endif

    assign sr_d = {bus.d_bit, sr_q[7:1]};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            sr_q         <= 8'hFF;
            bit_cnt_q    <= 3'd0;
            ones_cnt_q   <= '0;
            rx_data_q    <= 8'h00;
            byte_valid_q <= 1'b0;
            rcving_q     <= 1'b0;
            pkt_done_q   <= 1'b0;
            stuff_err_q  <= 1'b0;
            byte_err_q   <= 1'b0;
`ifdef RX_PKT_LEN_EN
            pkt_len_q    <= '0;
`endif
        end else begin
            byte_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            stuff_err_q  <= 1'b0;
            byte_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.bit_strobe) begin
                        sr_q <= sr_d;
                        if (sr_d == SYNC_PAT) begin
                            state_q    <= DATA;
                            rcving_q   <= 1'b1;
                            bit_cnt_q  <= 3'd0;
                            // The SYNC's trailing 1 already counts toward stuffing.
                            ones_cnt_q <= ONES_W'(1);
`ifdef RX_PKT_LEN_EN
                            pkt_len_q  <= '0;
`endif
                        end
                    end
                end
                DATA: begin
                    if (bus.eop) begin
                        rcving_q <= 1'b0;
                        state_q  <= EOP_WAIT;
                        if (bit_cnt_q == 3'd0) pkt_done_q <= 1'b1;
                        else                   byte_err_q <= 1'b1;
                    end else if (bus.bit_strobe) begin
                        if (ones_cnt_q == STUFF_MAX) begin
                            if (bus.d_bit) begin
                                stuff_err_q <= 1'b1;
                                rcving_q    <= 1'b0;
                                state_q     <= ERR_WAIT;
                            end else begin
                                ones_cnt_q <= '0;
                            end
                        end else begin
                            sr_q       <= sr_d;
                            ones_cnt_q <= bus.d_bit ? ones_cnt_q + ONES_W'(1) : '0;
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_q    <= sr_d;
                                byte_valid_q <= 1'b1;
`ifdef RX_PKT_LEN_EN
                                if (pkt_len_q != '1) pkt_len_q <= pkt_len_q + LEN_W'(1);
`endif
                            end
                        end
                    end
                end
                ERR_WAIT: begin
                    if (bus.eop) state_q <= EOP_WAIT;
                end
                EOP_WAIT: begin
                    if (!bus.eop) begin
                        state_q    <= IDLE;
                        sr_q       <= 8'hFF;
                        ones_cnt_q <= '0;
                        bit_cnt_q  <= 3'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.rcving     = rcving_q;
    assign bus.pkt_done   = pkt_done_q;
    assign bus.stuff_err  = stuff_err_q;
    assign bus.byte_err   = byte_err_q;
`ifdef RX_PKT_LEN_EN
    assign bus.pkt_len    = pkt_len_q;
`endif
endmodule

// File: tb/tb_usb_rx_unstuff_assembler.sv
// Scoreboard bench for usb_rx_unstuff_assembler: stimulus pushes expected pulses,
// a negedge monitor pops and compares every pulse the DUT raises.
module tb_usb_rx_unstuff_assembler;
    localparam int K_BYTE = 0;
    localparam int K_PKT  = 1;
    localparam int K_SERR = 2;
    localparam int K_BERR = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    usb_rx_unstuff_assembler_if bus();

    usb_rx_unstuff_assembler dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic expect_evt(input int k, input logic [7:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic on_evt(input int k, input logic [7:0] d);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse: got kind %0d data %0h expected no pulse", k, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == K_BYTE && e.data !== d)) begin
                failures++;
                $display("FAIL pulse_match: got kind %0d data %0h expected kind %0d data %0h",
                         k, d, e.kind, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (bus.byte_valid) on_evt(K_BYTE, bus.rx_data);
            if (bus.pkt_done)   on_evt(K_PKT, 8'h00);
            if (bus.stuff_err)  on_evt(K_SERR, 8'h00);
            if (bus.byte_err)   on_evt(K_BERR, 8'h00);
        end
    end

    task automatic send_bit(input logic b);
        bus.bit_strobe = 1'b1;
        bus.d_bit      = b;
        @(negedge clk);
        bus.bit_strobe = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic do_eop(input int n);
        bus.eop = 1'b1;
        repeat (n) @(negedge clk);
        bus.eop = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rcving"},     bus.rcving,     1'b0);
        chk({tag, "_byte_valid"}, bus.byte_valid, 1'b0);
        chk({tag, "_rx_data"},    bus.rx_data,    8'h00);
        chk({tag, "_pkt_done"},   bus.pkt_done,   1'b0);
        chk({tag, "_stuff_err"},  bus.stuff_err,  1'b0);
        chk({tag, "_byte_err"},   bus.byte_err,   1'b0);
`ifdef RX_PKT_LEN_EN
        chk({tag, "_pkt_len"},    bus.pkt_len,    0);
`endif
    endtask

    initial begin
        bus.bit_strobe = 1'b0;
        bus.d_bit      = 1'b0;
        bus.eop        = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        n_rst = 1'b1;
        @(negedge clk);

        // SYNC + 0xA5 + clean EOP
        send_sync();
        chk("a5_rcving_after_sync", bus.rcving, 1'b1);
        expect_evt(K_BYTE, 8'hA5);
        send_byte(8'hA5);
        expect_evt(K_PKT, 8'h00);
        do_eop(4);
        chk("a5_rcving_after_eop", bus.rcving, 1'b0);
        chk("a5_rx_data_holds", bus.rx_data, 8'hA5);

        // 0xFF with a stuffed zero after five data ones
        send_sync();
        expect_evt(K_BYTE, 8'hFF);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        expect_evt(K_PKT, 8'h00);
        do_eop(2);

        // Stuffing violation, then a SYNC-like pattern that must be ignored
        send_sync();
        expect_evt(K_SERR, 8'h00);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        chk("serr_rcving", bus.rcving, 1'b0);
        send_bit(1'b1);
        send_sync();
        chk("serr_ignores_sync", bus.rcving, 1'b0);
        do_eop(2);
        chk("serr_rx_data_holds", bus.rx_data, 8'hFF);

        // 0x3C then a partial byte before EOP
        send_sync();
        expect_evt(K_BYTE, 8'h3C);
        send_byte(8'h3C);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        expect_evt(K_BERR, 8'h00);
        do_eop(2);
        chk("berr_rcving", bus.rcving, 1'b0);
        chk("berr_rx_data_holds", bus.rx_data, 8'h3C);

        // EOP coinciding with a strobe on a byte boundary
        send_sync();
        expect_evt(K_BYTE, 8'h12);
        send_byte(8'h12);
        expect_evt(K_PKT, 8'h00);
        bus.eop        = 1'b1;
        bus.bit_strobe = 1'b1;
        bus.d_bit      = 1'b1;
        @(negedge clk);
        bus.bit_strobe = 1'b0;
        repeat (3) @(negedge clk);
        bus.eop = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-byte, then data without SYNC must not be assembled
        send_sync();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        n_rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        send_byte(8'hA5);
        chk("nosync_rcving", bus.rcving, 1'b0);
        chk("nosync_rx_data", bus.rx_data, 8'h00);
        send_sync();
        expect_evt(K_BYTE, 8'h5A);
        send_byte(8'h5A);
        expect_evt(K_PKT, 8'h00);
        do_eop(2);

        // Three-byte packet, then a fresh SYNC
        send_sync();
        expect_evt(K_BYTE, 8'h01);
        send_byte(8'h01);
        expect_evt(K_BYTE, 8'h02);
        send_byte(8'h02);
        expect_evt(K_BYTE, 8'h03);
        send_byte(8'h03);
        expect_evt(K_PKT, 8'h00);
        do_eop(2);
`ifdef RX_PKT_LEN_EN
        chk("pkt_len_three", bus.pkt_len, 3);
`endif
        send_sync();
`ifdef RX_PKT_LEN_EN
        chk("pkt_len_cleared", bus.pkt_len, 0);
`endif
        chk("last_rcving", bus.rcving, 1'b1);
        expect_evt(K_PKT, 8'h00);
        do_eop(2);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usb_rx_unstuff_assembler.md
Name: usb_rx_unstuff_assembler

Overview:
- Sits directly downstream of the NRZI decoder in the USB receive path.
- Consumes one decoded bit per bit-strobe, hunts for the SYNC pattern, removes stuffed bits, and assembles LSB-first bytes for the packet/PID layer.
- Flags stuffing violations and EOPs that do not fall on a byte boundary.

Parameters:
STUFF_LIMIT, 6, consecutive decoded 1s after which the next bit is a stuff bit
LEN_W, 7, width of pkt_len (used only with RX_PKT_LEN_EN)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
bit_strobe  input  1  one-clk pulse per received bit period (same strobe that clocks the NRZI decoder)
d_bit  input  1  decoded bit, valid when bit_strobe=1
eop  input  1  level; high while upstream detects SE0/EOP
rx_data  output  8  last assembled byte, LSB = first received bit
byte_valid  output  1  one-clk pulse: rx_data holds a new byte
rcving  output  1  high from SYNC match until EOP handled or error
pkt_done  output  1  one-clk pulse: clean EOP on byte boundary
stuff_err  output  1  one-clk pulse: 1 received where stuff 0 required
byte_err  output  1  one-clk pulse: EOP with partial byte pending
pkt_len  output  LEN_W  byte count of current/last packet (RX_PKT_LEN_EN only)

Behaviour:
- Reset (n_rst=0, async): all outputs 0, state IDLE, shift reg 8'hFF, bit_cnt 0, ones_cnt 0.
- Shift register: on accepted bit, sr <= {d_bit, sr[7:1]}; after 8 bits the first bit is sr[0].
- States: IDLE, DATA, ERR_WAIT, EOP_WAIT.
- IDLE: every bit_strobe shifts into sr; when the shifted value equals 8'h80 (decoded bits 0,0,0,0,0,0,0,1), go to DATA next cycle. Set rcving=1, bit_cnt=0, ones_cnt=1 (the SYNC's trailing 1 counts toward stuffing). eop in IDLE is ignored.
- DATA, bit_strobe, not a stuff slot: shift d_bit in. ones_cnt <= d_bit ? ones_cnt+1 : 0. bit_cnt increments mod 8.
  - On the 8th bit (bit_cnt 7→0): rx_data <= the completed shift value; byte_valid=1 the following cycle.
  - Latency: strobe of 8th bit → byte_valid high exactly 1 clk later.
- DATA, stuff slot (ones_cnt==STUFF_LIMIT):
  - d_bit=0: discard the bit; ones_cnt<=0; bit_cnt unchanged.
  - d_bit=1: stuff_err pulse; rcving<=0; go to ERR_WAIT.
- DATA with eop=1 (has priority over a simultaneous bit_strobe; that bit is discarded):
  - bit_cnt==0: pkt_done pulse.
  - bit_cnt!=0: byte_err pulse; the partial byte is dropped, no byte_valid.
  - Either case: rcving<=0, go to EOP_WAIT.
- ERR_WAIT: ignore bits until eop=1, then go to EOP_WAIT (no pulses).
- EOP_WAIT: when eop=0, go to IDLE with sr<=8'hFF, ones_cnt<=0, bit_cnt<=0.
- byte_valid and pkt_done may not coincide: the 8th bit and eop cannot share a strobe, because eop wins.
- rx_data holds its value until the next completed byte; it is not cleared at EOP.
- Reset asserted mid-packet: immediate return to reset values; no pulses generated.

Optional Feature:
- Macro: RX_PKT_LEN_EN.
- Defined: pkt_len clears to 0 on SYNC match and increments with each byte_valid, saturating at 2^LEN_W-1. It holds after EOP or error until the next SYNC match. Reset value is 0.
- Undefined: pkt_len port is absent and no counter logic is generated.

Test Plan:
- SYNC 0,0,0,0,0,0,0,1 then bits of 0xA5 LSB-first (1,0,1,0,0,1,0,1), then eop for 2 strobes → rcving=1 after SYNC; byte_valid once with rx_data=8'hA5; pkt_done once; rcving=0; back in IDLE after eop=0.
- SYNC then data 0xFF sent as 1,1,1,1,1,0(stuff),1,1,1 → ones_cnt=6 after 5 data 1s plus the SYNC 1; stuffed 0 dropped; rx_data=8'hFF; no stuff_err.
- SYNC then 6 ones then d_bit=1 → stuff_err pulse; no byte_valid; later bits ignored until eop; rcving=0.
- SYNC, 0x3C, then 3 bits, then eop → one byte_valid (8'h3C); byte_err pulse; no pkt_done.
- eop and bit_strobe in the same cycle at bit_cnt=0 → pkt_done, bit discarded. Also: n_rst pulsed low mid-byte → all outputs 0, a fresh SYNC is required to resume.
- RX_PKT_LEN_EN defined, SYNC plus 3 bytes plus eop → pkt_len=3 after EOP; resets to 0 on the next SYNC.
